// File: rtl/display_driver_row_scan.sv
// -----------------------------------------------------------------------------
// display_driver_row_scan
//
// Row-scan sequencer for a multiplexed LED panel driven with binary-coded
// modulation (BCM).  For every (row, plane) pair it asks an external row loader
// to shift the plane data into the panel.  It then blanks the panel, pulses the
// latch, and lights the LEDs for base_time << plane cycles.  Planes advance
// fastest, then rows.  A frame ends after the last plane of the last row.
//
// Parameters
//   rows       number of multiplexed panel rows (power of two, >= 2)
//   bit_depth  number of BCM bit planes per row (>= 1)
//   base_time  display-on cycles for bit plane 0 (>= 1)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   enable      run request; low parks the sequencer in IDLE between planes
//   load        level request to the row loader (held until complete)
//   complete    single-cycle done strobe from the row loader
//   load_row    row address handed to the loader
//   load_plane  bit plane handed to the loader
//   row         panel row address currently latched / displayed
//   oe          panel output enable, high = LEDs lit
//   lat         panel latch strobe, one cycle
//   frame_done  one-cycle pulse after the last plane of the last row
// -----------------------------------------------------------------------------
module display_driver_row_scan #(
   parameter  int rows      = 16,
   parameter  int bit_depth = 4,
   parameter  int base_time = 8,
   localparam int RW        = $clog2(rows),
   localparam int PW        = (bit_depth > 1) ? $clog2(bit_depth) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   output logic          load,
   input  logic          complete,
   output logic [RW-1:0] load_row,
   output logic [PW-1:0] load_plane,
   output logic [RW-1:0] row,
   output logic          oe,
   output logic          lat,
   output logic          frame_done
);

   // The longest plane (bit_depth-1) sets the display counter width.  The
   // counter is loaded with duration-1 and counts down to zero, so it only
   // has to hold MAX_TIME-1.  One spare code is kept for margin.
   localparam int            MAX_TIME   = base_time << (bit_depth - 1);
   localparam int            CW         = $clog2(MAX_TIME + 1);
   localparam logic [RW-1:0] LAST_ROW   = RW'(rows - 1);
   localparam logic [PW-1:0] LAST_PLANE = PW'(bit_depth - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_BLANK,
      S_LATCH,
      S_DISPLAY
   } state_t;

   state_t        state;
   logic [CW-1:0] disp_cnt;

   logic          plane_wrap;
   logic          row_wrap;
   logic [PW-1:0] next_plane;
   logic [RW-1:0] next_row;

   // Terminal count for a plane: the plane is lit for base_time << p cycles.
   // The counter runs from that value minus one down to zero.
   function automatic logic [CW-1:0] plane_last(input logic [PW-1:0] p);
      return CW'((base_time << p) - 1);
   endfunction

   // Scan position that follows the current one.  The wrap checks are written
   // out explicitly so that a bit_depth that is not a power of two still
   // wraps at bit_depth-1.
   assign plane_wrap = (load_plane == LAST_PLANE);
   assign row_wrap   = (load_row == LAST_ROW);
   assign next_plane = plane_wrap ? '0 : load_plane + 1'b1;
   assign next_row   = plane_wrap ? (row_wrap ? '0 : load_row + 1'b1) : load_row;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         load       <= 1'b0;
         oe         <= 1'b0;
         lat        <= 1'b0;
         frame_done <= 1'b0;
         row        <= '0;
         load_row   <= '0;
         load_plane <= '0;
         disp_cnt   <= '0;
      end else begin
         frame_done <= 1'b0;

         case (state)
            S_IDLE: begin
               oe   <= 1'b0;
               lat  <= 1'b0;
               load <= 1'b0;
               if (enable) begin
                  load  <= 1'b1;
                  state <= S_LOAD;
               end
            end

            // Hold the load request until the loader reports the shift is
            // done.  enable is deliberately ignored here so that a plane
            // which has started always completes.
            S_LOAD: begin
               if (complete) begin
                  load  <= 1'b0;
                  row   <= load_row;
                  state <= S_BLANK;
               end
            end

            // One dark cycle with the new row address settled before the
            // latch strobe.
            S_BLANK: begin
               lat   <= 1'b1;
               state <= S_LATCH;
            end

            // oe is raised together with lat's fall.  As a result, oe and lat
            // never overlap, and oe is low through both BLANK and LATCH.
            S_LATCH: begin
               lat      <= 1'b0;
               oe       <= 1'b1;
               disp_cnt <= plane_last(load_plane);
               state    <= S_DISPLAY;
            end

            S_DISPLAY: begin
               if (disp_cnt == '0) begin
                  oe         <= 1'b0;
                  load_plane <= next_plane;
                  load_row   <= next_row;
                  if (plane_wrap && row_wrap) begin
                     frame_done <= 1'b1;
                  end
                  // Plane boundary: the only point besides IDLE where a run
                  // request is honoured.  Scan position is kept when parking.
                  if (enable) begin
                     load  <= 1'b1;
                     state <= S_LOAD;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  disp_cnt <= disp_cnt - 1'b1;
               end
            end

            default: begin
               load  <= 1'b0;
               oe    <= 1'b0;
               lat   <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_driver_row_scan.sv
// -----------------------------------------------------------------------------
// tb_display_driver_row_scan
//
// Directed bench for display_driver_row_scan with rows=4, bit_depth=2,
// base_time=2.  Each loaded plane pushes its expected panel row and lit
// duration onto a scoreboard.  The entry is popped when the DUT drops oe at
// the end of the plane.
// -----------------------------------------------------------------------------
module tb_display_driver_row_scan;

   localparam int ROWS = 4;
   localparam int BD   = 2;
   localparam int BT   = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       complete;
   logic       load;
   logic [1:0] load_row;
   logic [0:0] load_plane;
   logic [1:0] row;
   logic       oe;
   logic       lat;
   logic       frame_done;

   display_driver_row_scan #(
      .rows      (ROWS),
      .bit_depth (BD),
      .base_time (BT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load),
      .complete   (complete),
      .load_row   (load_row),
      .load_plane (load_plane),
      .row        (row),
      .oe         (oe),
      .lat        (lat),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int row;
      int dur;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one plane starting from a sample point in the first LOAD cycle.
   // mode 0: normal; mode 1: drop enable during DISPLAY, then re-enable;
   // mode 2: assert reset during the second DISPLAY cycle.
   task automatic do_plane(input int r, input int p, input int load_cycles, input int mode);
      exp_t e;
      exp_t got;
      int   n;
      int   nr;
      int   np;
      int   fd_exp;

      check("load_start",  32'(load), 1);
      check("load_row",    32'(load_row), r);
      check("load_plane",  32'(load_plane), p);
      check("load_oe",     32'(oe), 0);
      check("load_lat",    32'(lat), 0);
      for (int i = 1; i < load_cycles; i++) begin
         @(negedge clk);
         check("load_held", 32'(load), 1);
         check("fd_low",    32'(frame_done), 0);
      end

      complete = 1'b1;
      e.row = r;
      e.dur = BT << p;
      sb.push_back(e);
      @(negedge clk);
      complete = 1'b0;

      check("blank_load", 32'(load), 0);
      check("blank_row",  32'(row), r);
      check("blank_oe",   32'(oe), 0);
      check("blank_lat",  32'(lat), 0);
      @(negedge clk);
      check("latch_lat",  32'(lat), 1);
      check("latch_oe",   32'(oe), 0);

      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!oe) break;
         n++;
         check("disp_lat", 32'(lat), 0);
         if (mode == 1 && i == 0) enable = 1'b0;
         if (mode == 2 && i == 1) begin
            rst = 1'b0;
            #1;
            check("rst_oe",   32'(oe), 0);
            check("rst_load", 32'(load), 0);
            check("rst_lat",  32'(lat), 0);
            got = sb.pop_front();
            repeat (2) @(negedge clk);
            check("rst_row",        32'(row), 0);
            check("rst_load_row",   32'(load_row), 0);
            check("rst_load_plane", 32'(load_plane), 0);
            check("rst_fd",         32'(frame_done), 0);
            check("rst_oe_hold",    32'(oe), 0);
            rst = 1'b1;
            @(negedge clk);
            return;
         end
      end
      check("disp_bound", (n < 100) ? 32'd1 : 32'd0, 1);

      got = sb.pop_front();
      check("disp_row", 32'(row), got.row);
      check("disp_len", n, got.dur);

      np     = (p == BD - 1) ? 0 : p + 1;
      nr     = (p == BD - 1) ? ((r == ROWS - 1) ? 0 : r + 1) : r;
      fd_exp = (p == BD - 1 && r == ROWS - 1) ? 1 : 0;
      check("frame_done", 32'(frame_done), fd_exp);
      check("next_row",   32'(load_row), nr);
      check("next_plane", 32'(load_plane), np);
      check("post_oe",    32'(oe), 0);

      if (mode == 1) begin
         check("idle_load", 32'(load), 0);
         repeat (3) begin
            @(negedge clk);
            check("idle_load_hold",  32'(load), 0);
            check("idle_row_kept",   32'(load_row), nr);
            check("idle_plane_kept", 32'(load_plane), np);
            check("idle_oe",         32'(oe), 0);
         end
         enable = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      rst      = 1'b0;
      enable   = 1'b0;
      complete = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_load",       32'(load), 0);
      check("reset_oe",         32'(oe), 0);
      check("reset_lat",        32'(lat), 0);
      check("reset_fd",         32'(frame_done), 0);
      check("reset_row",        32'(row), 0);
      check("reset_load_row",   32'(load_row), 0);
      check("reset_load_plane", 32'(load_plane), 0);

      rst = 1'b1;
      @(negedge clk);
      check("idle_no_enable", 32'(load), 0);
      complete = 1'b1;
      @(negedge clk);
      complete = 1'b0;
      check("idle_ignores_complete", 32'(load), 0);

      enable = 1'b1;
      @(negedge clk);

      // First frame: row 0 with a 5-cycle load, then the rest of the panel.
      do_plane(0, 0, 5, 0);
      do_plane(0, 1, 2, 0);
      for (int r = 1; r < ROWS; r++) begin
         for (int p = 0; p < BD; p++) begin
            do_plane(r, p, 2 + r, 0);
         end
      end

      // Second frame: park mid-frame, resume, then reset during row 2.
      do_plane(0, 0, 3, 0);
      do_plane(0, 1, 2, 1);
      do_plane(1, 0, 2, 0);
      do_plane(1, 1, 4, 0);
      do_plane(2, 0, 2, 2);

      // Scan restarts from the top after reset.
      do_plane(0, 0, 2, 0);
      do_plane(0, 1, 3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
